ex_hazard_ctrl: RTL and testbench
=================================

Name: ex_hazard_ctrl

Overview:
- Consumer-side control for the ID/EX pipeline register.
- Reads the EX-stage control and register fields latched by ID/EX, together with the decode-stage source registers and the EX/MEM and MEM/WB destinations.
- Generates load-use stalls, taken-branch flushes and ALU operand forwarding selects.
- Multi-cycle stalls and flushes are sequenced by an internal FSM and down-counter, so longer memory and branch latencies need no pipeline-register changes.

Parameters:
- LOAD_STALL_CYCLES, 1: bubbles inserted per load-use hazard. Legal range 1..15.
- FLUSH_CYCLES, 1: cycles of IF/ID flush plus ID/EX bubble per taken branch. Legal range 1..3.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- MemRead_ex  in  1  MemRead from ID/EX.
- RegWrite_ex  in  1  RegWrite from ID/EX.
- Branch_ex  in  1  Branch from ID/EX.
- branch_cond_ex  in  1  branch condition true, from EX ALU.
- RD_ex  in  5  rd from ID/EX.
- RS1_ex, RS2_ex  in  5  rs1/rs2 from ID/EX.
- RS1_id, RS2_id  in  5  rs1/rs2 of the instruction in ID.
- uses_rs1_id, uses_rs2_id  in  1  ID instruction actually reads rs1/rs2.
- RegWrite_mem, RD_mem  in  1/5  EX/MEM destination.
- RegWrite_wb, RD_wb  in  1/5  MEM/WB destination.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID load enable.
- if_id_flush  out  1  IF/ID clear.
- id_ex_bubble  out  1  zero ID/EX control inputs.
- forward_a, forward_b  out  2  operand select: 00 register file, 10 EX/MEM, 01 MEM/WB.
- stall_cnt, flush_cnt  out  32  performance counters (see Optional Feature).

Behaviour:
- States: S_RUN, S_STALL, S_FLUSH. 4-bit down-counter cnt.
- While reset=0:
  - state=S_RUN, cnt=0.
  - Outputs forced to pc_write=0, if_id_write=0, if_id_flush=1, id_ex_bubble=1, forward_a/b=00, counters=0.
  - Reset mid-stall or mid-flush abandons the sequence.
- Definitions:
  - branch_taken = Branch_ex & branch_cond_ex.
  - load_use = MemRead_ex & (RD_ex != 0) & ((uses_rs1_id & RD_ex == RS1_id) | (uses_rs2_id & RD_ex == RS2_id)).
- Default outputs (no hazard): pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0.
- Priority: branch_taken > active flush > active stall > load_use.
- S_RUN:
  - branch_taken:
    - Same cycle: if_id_flush=1, id_ex_bubble=1, pc_write=1.
    - If FLUSH_CYCLES>1: cnt<=FLUSH_CYCLES-1, go to S_FLUSH.
  - else load_use:
    - Same cycle: pc_write=0, if_id_write=0, id_ex_bubble=1.
    - If LOAD_STALL_CYCLES>1: cnt<=LOAD_STALL_CYCLES-1, go to S_STALL.
- S_STALL:
  - Outputs as for load_use.
  - cnt decrements each cycle; at cnt==1 the next state is S_RUN.
  - load_use is not re-evaluated here; ID/EX now holds a bubble.
  - branch_taken overrides: flush outputs, then cnt<=FLUSH_CYCLES-1, go to S_FLUSH, or go to S_RUN if FLUSH_CYCLES==1.
- S_FLUSH:
  - Outputs if_id_flush=1, id_ex_bubble=1, pc_write=1, if_id_write=1.
  - cnt decrements; at cnt==1 go to S_RUN.
  - load_use is ignored.
- Forwarding (combinational, all states), forward_a:
  - 10 if RegWrite_mem & RD_mem!=0 & RD_mem==RS1_ex.
  - else 01 if RegWrite_wb & RD_wb!=0 & RD_wb==RS1_ex.
  - else 00.
  - forward_b is identical using RS2_ex. EX/MEM wins over MEM/WB.
- Latency: hazard outputs take effect in the detection cycle, with no registered delay on the first cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - stall_cnt increments by 1 on every cycle with pc_write=0.
  - flush_cnt increments on every cycle with if_id_flush=1.
  - Both are 32-bit, wrap from 0xFFFFFFFF to 0, and clear on reset.
- Undefined: no counter registers; stall_cnt and flush_cnt are tied to 0.

Test Plan:
- LOAD_STALL_CYCLES=1, ID/EX load RD_ex=5, RS1_id=5, uses_rs1_id=1 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1, then defaults; stall_cnt=1.
- LOAD_STALL_CYCLES=3, same hazard, MemRead_ex dropping to 0 after the first cycle -> exactly 3 consecutive stall cycles, then S_RUN.
- FLUSH_CYCLES=2, Branch_ex=1, branch_cond_ex=1, simultaneous load_use -> 2 cycles of if_id_flush=1 with pc_write=1, no stall; flush_cnt=2.
- RD_mem=RD_wb=7, both RegWrite=1, RS1_ex=7; then RD_mem=0 with RS2_ex=0 -> forward_a=10; forward_b=00 (x0 never forwarded).
- reset driven 0 mid S_STALL (cnt=2) -> outputs forced immediately, without waiting for clk; after release, state S_RUN with default outputs.
- RD_ex=0 with MemRead_ex=1, RS1_id=0 -> no stall.

Source files
------------

// File: rtl/ex_hazard_ctrl_if.sv
// ex_hazard_ctrl_if: ID/EX hazard-control bundle; master drives pipeline fields, slave returns controls.
interface ex_hazard_ctrl_if;
    logic        MemRead_ex, RegWrite_ex, Branch_ex, branch_cond_ex;
    logic [4:0]  RD_ex, RS1_ex, RS2_ex, RS1_id, RS2_id;
    logic        uses_rs1_id, uses_rs2_id;
    logic        RegWrite_mem, RegWrite_wb;
    logic [4:0]  RD_mem, RD_wb;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] stall_cnt, flush_cnt;

    modport master (
        output MemRead_ex, RegWrite_ex, Branch_ex, branch_cond_ex,
        output RD_ex, RS1_ex, RS2_ex, RS1_id, RS2_id, uses_rs1_id, uses_rs2_id,
        output RegWrite_mem, RD_mem, RegWrite_wb, RD_wb,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
        input  forward_a, forward_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  MemRead_ex, RegWrite_ex, Branch_ex, branch_cond_ex,
        input  RD_ex, RS1_ex, RS2_ex, RS1_id, RS2_id, uses_rs1_id, uses_rs2_id,
        input  RegWrite_mem, RD_mem, RegWrite_wb, RD_wb,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
        output forward_a, forward_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: load-use stall, taken-branch flush and operand forwarding for the EX stage.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module ex_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1
) (
    input logic             clk,
    input logic             reset,
    ex_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH} state_t;

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       branch_taken, load_use, stall, flush;

    assign branch_taken = bus.Branch_ex & bus.branch_cond_ex;
    assign load_use = bus.MemRead_ex & (bus.RD_ex != 5'd0) &
                      ((bus.uses_rs1_id & (bus.RD_ex == bus.RS1_id)) |
                       (bus.uses_rs2_id & (bus.RD_ex == bus.RS2_id)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RUN;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // A taken branch always wins, even inside an ongoing stall or flush sequence.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        stall    = 1'b0;
        flush    = 1'b0;
        if (branch_taken) begin
            flush    = 1'b1;
            state_nx = (FLUSH_CYCLES > 1) ? S_FLUSH : S_RUN;
            cnt_nx   = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
        end else if (state == S_FLUSH) begin
            flush    = 1'b1;
            cnt_nx   = cnt - 4'd1;
            state_nx = (cnt == 4'd1) ? S_RUN : S_FLUSH;
        end else if (state == S_STALL) begin
            stall    = 1'b1;
            cnt_nx   = cnt - 4'd1;
            state_nx = (cnt == 4'd1) ? S_RUN : S_STALL;
        end else if (load_use) begin
            stall    = 1'b1;
            state_nx = (LOAD_STALL_CYCLES > 1) ? S_STALL : S_RUN;
            cnt_nx   = (LOAD_STALL_CYCLES > 1) ? 4'(LOAD_STALL_CYCLES - 1) : 4'd0;
        end
    end

    // Reset acts combinationally on the outputs so the pipeline freezes without waiting for clk.
    assign bus.pc_write     = reset & ~stall;
    assign bus.if_id_write  = reset & ~stall;
    assign bus.if_id_flush  = ~reset | flush;
    assign bus.id_ex_bubble = ~reset | flush | stall;

    assign bus.forward_a = !reset ? 2'b00 :
        (bus.RegWrite_mem && bus.RD_mem != 5'd0 && bus.RD_mem == bus.RS1_ex) ? 2'b10 :
        (bus.RegWrite_wb  && bus.RD_wb  != 5'd0 && bus.RD_wb  == bus.RS1_ex) ? 2'b01 : 2'b00;
    assign bus.forward_b = !reset ? 2'b00 :
        (bus.RegWrite_mem && bus.RD_mem != 5'd0 && bus.RD_mem == bus.RS2_ex) ? 2'b10 :
        (bus.RegWrite_wb  && bus.RD_wb  != 5'd0 && bus.RD_wb  == bus.RS2_ex) ? 2'b01 : 2'b00;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            stall_q <= stall_q + {31'd0, stall};
            flush_q <= flush_q + {31'd0, flush};
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.flush_cnt = flush_q;
`else
    assign bus.stall_cnt = 32'd0;
    assign bus.flush_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: two instances (1/1 and 3/2 stall/flush cycles) share directed stimulus;
// expected responses are queued per cycle and checked by an independent monitor.
module tb_ex_hazard_ctrl;
`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    // Hazard control nibble order: {pc_write, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [3:0] RUN = 4'b1100, STL = 4'b0001, FLS = 4'b1111, RST = 4'b0011;

    typedef struct {
        string       name;
        logic [7:0]  e1, e3;
        logic [63:0] c1, c3;
    } item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mr, br, bc, u1, u2, rwm, rww;
    logic [4:0] rd, rs1i, rs2i, rdm, rdw, rs1e, rs2e;
    item_t sbq[$];
    int total = 0, passed = 0;
    int s1 = 0, f1 = 0, s3 = 0, f3 = 0;

    always #5 clk = ~clk;

    ex_hazard_ctrl_if bus [2] ();

    genvar g;
    for (g = 0; g < 2; g++) begin : gd
        assign bus[g].MemRead_ex     = mr;
        assign bus[g].RegWrite_ex    = 1'b1;
        assign bus[g].Branch_ex      = br;
        assign bus[g].branch_cond_ex = bc;
        assign bus[g].RD_ex          = rd;
        assign bus[g].RS1_ex         = rs1e;
        assign bus[g].RS2_ex         = rs2e;
        assign bus[g].RS1_id         = rs1i;
        assign bus[g].RS2_id         = rs2i;
        assign bus[g].uses_rs1_id    = u1;
        assign bus[g].uses_rs2_id    = u2;
        assign bus[g].RegWrite_mem   = rwm;
        assign bus[g].RD_mem         = rdm;
        assign bus[g].RegWrite_wb    = rww;
        assign bus[g].RD_wb          = rdw;
        ex_hazard_ctrl #(
            .LOAD_STALL_CYCLES(g == 0 ? 1 : 3),
            .FLUSH_CYCLES     (g == 0 ? 1 : 2)
        ) dut (
            .clk  (clk),
            .reset(rst),
            .bus  (bus[g])
        );
    end

    task automatic drive(input logic a_mr, a_br, a_bc, input logic [4:0] a_rd, a_rs1i,
                         input logic a_u1, input logic [4:0] a_rs2i, input logic a_u2,
                         input logic a_rwm, input logic [4:0] a_rdm, input logic a_rww,
                         input logic [4:0] a_rdw, a_rs1e, a_rs2e);
        mr = a_mr; br = a_br; bc = a_bc; rd = a_rd; rs1i = a_rs1i; u1 = a_u1;
        rs2i = a_rs2i; u2 = a_u2; rwm = a_rwm; rdm = a_rdm; rww = a_rww;
        rdw = a_rdw; rs1e = a_rs1e; rs2e = a_rs2e;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expectation for the current cycle; counters reflect completed earlier cycles.
    task automatic expect_cyc(input string n, input logic [3:0] h1, h3, input logic [1:0] fa, fb);
        item_t it;
        it.name = n;
        it.e1 = {h1, fa, fb};
        it.e3 = {h3, fa, fb};
        it.c1 = PERF ? {32'(s1), 32'(f1)} : 64'd0;
        it.c3 = PERF ? {32'(s3), 32'(f3)} : 64'd0;
        sbq.push_back(it);
        if (!rst) begin
            s1 = 0; f1 = 0; s3 = 0; f3 = 0;
        end else begin
            s1 += int'(!h1[3]); f1 += int'(h1[1]);
            s3 += int'(!h3[3]); f3 += int'(h3[1]);
        end
    endtask

    task automatic chk(input string n, input logic [63:0] act, exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, required %h", n, act, exp);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            item_t it;
            it = sbq.pop_front();
            chk({it.name, "/ctl_1_1"}, 64'({bus[0].pc_write, bus[0].if_id_write, bus[0].if_id_flush,
                 bus[0].id_ex_bubble, bus[0].forward_a, bus[0].forward_b}), 64'(it.e1));
            chk({it.name, "/ctl_3_2"}, 64'({bus[1].pc_write, bus[1].if_id_write, bus[1].if_id_flush,
                 bus[1].id_ex_bubble, bus[1].forward_a, bus[1].forward_b}), 64'(it.e3));
            chk({it.name, "/cnt_1_1"}, {bus[0].stall_cnt, bus[0].flush_cnt}, it.c1);
            chk({it.name, "/cnt_3_2"}, {bus[1].stall_cnt, bus[1].flush_cnt}, it.c3);
        end
    end

    initial begin
        //    mr br bc rd  rs1i u1 rs2i u2 rwm rdm rww rdw rs1e rs2e
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(); expect_cyc("reset", RST, RST, 2'b00, 2'b00);
        step(); rst = 1'b1; expect_cyc("idle", RUN, RUN, 2'b00, 2'b00);
        step(); drive(1, 0, 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("lu_c1", STL, STL, 2'b00, 2'b00);
        step(); drive(0, 0, 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("lu_c2", RUN, STL, 2'b00, 2'b00);
        step(); expect_cyc("lu_c3", RUN, STL, 2'b00, 2'b00);
        step(); expect_cyc("lu_done", RUN, RUN, 2'b00, 2'b00);
        step(); drive(1, 1, 1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("br_lu", FLS, FLS, 2'b00, 2'b00);
        step(); drive(1, 0, 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("flush2_lu", STL, FLS, 2'b00, 2'b00);
        step(); drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("br_not_taken", RUN, RUN, 2'b00, 2'b00);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7, 7, 0);
        expect_cyc("fwd_mem", RUN, RUN, 2'b10, 2'b00);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7, 7, 0);
        expect_cyc("fwd_wb_x0", RUN, RUN, 2'b01, 2'b00);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 3, 3, 3);
        expect_cyc("fwd_mem_wins", RUN, RUN, 2'b10, 2'b10);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 3, 3, 3);
        expect_cyc("fwd_wb_only", RUN, RUN, 2'b01, 2'b01);
        step(); drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("rd_x0", RUN, RUN, 2'b00, 2'b00);
        step(); drive(1, 0, 0, 9, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
        expect_cyc("lu_rs2", STL, STL, 2'b00, 2'b00);
        // Instance 3/2 is mid-stall with cnt=2; reset lands between clock edges.
        step(); rst = 1'b0; drive(1, 0, 0, 9, 0, 0, 9, 1, 1, 7, 0, 0, 7, 0);
        expect_cyc("async_rst", RST, RST, 2'b00, 2'b00);
        step(); rst = 1'b1; drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("rst_release", RUN, RUN, 2'b00, 2'b00);
        step(); drive(1, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("unused_rs1", RUN, RUN, 2'b00, 2'b00);
        step(); drive(1, 0, 0, 5, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("lu_again", STL, STL, 2'b00, 2'b00);
        step(); drive(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("br_in_stall", FLS, FLS, 2'b00, 2'b00);
        step(); drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_cyc("flush_tail", RUN, FLS, 2'b00, 2'b00);
        step(); expect_cyc("final_run", RUN, RUN, 2'b00, 2'b00);
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(negedge clk);
        #1;
        if (sbq.size() > 0) begin
            total++;
            $display("FAIL drain: %0d items left, required 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
